// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// FSM states, opcode classes and the control-word layout.
// Latency: n/a (types and constants only). Backpressure: n/a.
package control_sequencer_pkg;

  // Instruction opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01111;
  localparam logic [4:0] OP_NOT  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_SHR  = 4'b0101,
    ALU_SHL  = 4'b0110,
    ALU_NEG  = 4'b0111,
    ALU_NOT  = 4'b1000
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_E7, S_HALT
  } state_e;

  // Execution-phase behaviour shared by groups of opcodes
  typedef enum logic [2:0] {
    CLS_ALU3, CLS_UNARY, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic    pc_out;
    logic    pc_in;
    logic    inc_pc;
    logic    mar_in;
    logic    mdr_in;
    logic    mdr_out;
    logic    ir_in;
    logic    y_in;
    logic    z_in;
    logic    zlow_out;
    logic    read;
    logic    write;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    r_in;
    logic    r_out;
    logic    ba_out;
    logic    c_out;
    alu_op_e alu_op;
    logic    halted;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Opcode classifier: ir[31:27] -> execution class, ALU code, undefined flag.
// Latency: purely combinational. Backpressure: none.
// Ports: op_i (5-bit opcode) -> op_class_o, alu_op_o, illegal_o.
module opcode_decode
  import control_sequencer_pkg::*;
(
  input  logic [4:0] op_i,
  output op_class_e  op_class_o,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    op_class_o = CLS_ILLEGAL;
    alu_op_o   = ALU_NONE;
    illegal_o  = 1'b0;
    case (op_i)
      OP_ADD:  begin op_class_o = CLS_ALU3;  alu_op_o = ALU_ADD; end
      OP_SUB:  begin op_class_o = CLS_ALU3;  alu_op_o = ALU_SUB; end
      OP_AND:  begin op_class_o = CLS_ALU3;  alu_op_o = ALU_AND; end
      OP_OR:   begin op_class_o = CLS_ALU3;  alu_op_o = ALU_OR;  end
      OP_SHR:  begin op_class_o = CLS_ALU3;  alu_op_o = ALU_SHR; end
      OP_SHL:  begin op_class_o = CLS_ALU3;  alu_op_o = ALU_SHL; end
      OP_NEG:  begin op_class_o = CLS_UNARY; alu_op_o = ALU_NEG; end
      OP_NOT:  begin op_class_o = CLS_UNARY; alu_op_o = ALU_NOT; end
      // Loads and stores use the ALU adder for base + displacement
      OP_LD:   begin op_class_o = CLS_LD;    alu_op_o = ALU_ADD; end
      OP_ST:   begin op_class_o = CLS_ST;    alu_op_o = ALU_ADD; end
      OP_NOP:  op_class_o = CLS_NOP;
      OP_HALT: op_class_o = CLS_HALT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch (F0-F2) then execute (E3-E7) strobes.
// Latency: one state per clock; ADD takes 6 cycles F0 to F0 with zero-wait memory.
// Backpressure: F1, LD E6 and ST E7 stall until mem_ready; clear overrides all.
// Ports: clock/clear, run (start from IDLE), ir (opcode ir[31:27]), mem_ready;
// outputs are datapath strobes, memory Read/Write, register selects, alu_op,
// halted (sticky until clear) and illegal (E3 pulse on undefined opcode).
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic        illegal
);

  state_e    state_q, state_d;
  op_class_e op_class;
  alu_op_e   dec_alu;
  logic      dec_illegal;
  ctrl_t     ctrl;

  // Operand fields are consumed by the datapath, not by the sequencer
  logic ir_unused;
  assign ir_unused = ^ir[26:0];

  opcode_decode u_decode (
    .op_i       (ir[31:27]),
    .op_class_o (op_class),
    .alu_op_o   (dec_alu),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (mem_ready) state_d = S_F2;
      S_F2:   state_d = S_E3;
      S_E3: begin
        case (op_class)
          CLS_NOP, CLS_ILLEGAL: state_d = S_F0;
          CLS_HALT:             state_d = S_HALT;
          default:              state_d = S_E4;
        endcase
      end
      S_E4:   state_d = (op_class == CLS_UNARY) ? S_F0 : S_E5;
      S_E5:   state_d = (op_class == CLS_LD || op_class == CLS_ST) ? S_E6 : S_F0;
      S_E6: begin
        if (op_class == CLS_LD)      state_d = mem_ready ? S_E7 : S_E6;
        else if (op_class == CLS_ST) state_d = S_E7;
        else                         state_d = S_F0;
      end
      S_E7: begin
        // A store holds its Write here until memory accepts it
        if (op_class == CLS_ST) state_d = mem_ready ? S_F0 : S_E7;
        else                    state_d = S_F0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Output decode depends on state_q and ir only; no input path reaches it
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_IDLE: ;
      S_F0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
      end
      S_F1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      S_F2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      S_E3: begin
        case (op_class)
          CLS_ALU3: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = dec_alu; ctrl.z_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
          end
          default: ctrl.illegal = dec_illegal;
        endcase
      end
      S_E4: begin
        case (op_class)
          CLS_ALU3: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = dec_alu; ctrl.z_in = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.c_out = 1'b1; ctrl.alu_op = dec_alu; ctrl.z_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_E5: begin
        case (op_class)
          CLS_ALU3: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_E6: begin
        case (op_class)
          CLS_LD: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
          CLS_ST: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
          default: ;
        endcase
      end
      S_E7: begin
        case (op_class)
          CLS_LD: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

  assign PCout   = ctrl.pc_out;
  assign PCin    = ctrl.pc_in;
  assign IncPC   = ctrl.inc_pc;
  assign MARin   = ctrl.mar_in;
  assign MDRin   = ctrl.mdr_in;
  assign MDRout  = ctrl.mdr_out;
  assign IRin    = ctrl.ir_in;
  assign Yin     = ctrl.y_in;
  assign Zin     = ctrl.z_in;
  assign Zlowout = ctrl.zlow_out;
  assign Read    = ctrl.read;
  assign Write   = ctrl.write;
  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign Rin     = ctrl.r_in;
  assign Rout    = ctrl.r_out;
  assign BAout   = ctrl.ba_out;
  assign Cout    = ctrl.c_out;
  assign alu_op  = ctrl.alu_op;
  assign halted  = ctrl.halted;
  assign illegal = ctrl.illegal;

endmodule
